// File: rtl/button_event_fsm_pkg.sv
// button_event_fsm_pkg: state encodings and default tick counts for button_event_fsm.
package button_event_fsm_pkg;
    localparam logic [2:0] IDLE           = 3'd0;
    localparam logic [2:0] PRESSED        = 3'd1;
    localparam logic [2:0] LONG_HELD      = 3'd2;
    localparam logic [2:0] WAIT_SECOND    = 3'd3;
    localparam logic [2:0] SECOND_PRESSED = 3'd4;
    localparam int LONG_TICKS_DEF   = 100_000_000;
    localparam int DOUBLE_TICKS_DEF = 25_000_000;
endpackage

// File: rtl/button_event_fsm_edge_detect.sv
// button_event_fsm_edge_detect: rise/fall strobes of the debounced level; resets high so a held button is not a press.
module button_event_fsm_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic clean,
    output logic rise,
    output logic fall
);
    logic clean_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clean_d <= 1'b1;
        else        clean_d <= clean;
    end
    assign rise = clean & ~clean_d;
    assign fall = ~clean & clean_d;
endmodule

// File: rtl/button_event_fsm.sv
// button_event_fsm: classifies debounced presses into short/long/double one-cycle events with a wrapping event count.
module button_event_fsm
    import button_event_fsm_pkg::*;
#(
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int DOUBLE_TICKS = DOUBLE_TICKS_DEF,
    parameter int TMR_W        = 27,
    parameter int CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLEAN,
    output logic             SHORT_PRESS,
    output logic             LONG_PRESS,
    output logic             DOUBLE_PRESS,
    output logic             HELD,
    output logic [CNT_W-1:0] PRESS_COUNT
);
    localparam logic [TMR_W-1:0] LONG_MAX   = TMR_W'(LONG_TICKS - 1);
    localparam logic [TMR_W-1:0] DOUBLE_MAX = TMR_W'(DOUBLE_TICKS - 1);

    logic             rise, fall;
    logic [2:0]       state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             short_nxt, long_nxt, double_nxt, held_nxt;

    button_event_fsm_edge_detect u_edge (
        .clk   (CLK),
        .rst_n (RST_N),
        .clean (CLEAN),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            timer        <= '0;
            SHORT_PRESS  <= 1'b0;
            LONG_PRESS   <= 1'b0;
            DOUBLE_PRESS <= 1'b0;
            HELD         <= 1'b0;
            PRESS_COUNT  <= '0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            SHORT_PRESS  <= short_nxt;
            LONG_PRESS   <= long_nxt;
            DOUBLE_PRESS <= double_nxt;
            HELD         <= held_nxt;
            PRESS_COUNT  <= PRESS_COUNT + CNT_W'(short_nxt | long_nxt | double_nxt);
        end
    end

    // The timer stops at each compare value because leaving the state is the only way past it.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            IDLE: if (rise) begin
                state_nxt = PRESSED;
                timer_nxt = '0;
            end
            PRESSED: if (fall) begin
                state_nxt = WAIT_SECOND;
                timer_nxt = '0;
            end else if (timer == LONG_MAX) state_nxt = LONG_HELD;
            else timer_nxt = timer + 1'b1;
            LONG_HELD: if (fall) state_nxt = IDLE;
            WAIT_SECOND: if (rise) begin
                state_nxt = SECOND_PRESSED;
                timer_nxt = '0;
            end else if (timer == DOUBLE_MAX) state_nxt = IDLE;
            else timer_nxt = timer + 1'b1;
            SECOND_PRESSED: if (fall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        long_nxt   = state == PRESSED && !fall && timer == LONG_MAX;
        short_nxt  = state == WAIT_SECOND && !rise && timer == DOUBLE_MAX;
        double_nxt = state == SECOND_PRESSED && fall;
        held_nxt   = state_nxt == LONG_HELD;
    end
endmodule

// File: tb/tb_button_event_fsm.sv
// tb_button_event_fsm: directed presses with a queue of expected events checked by an independent monitor.
module tb_button_event_fsm;
    localparam logic [2:0] EV_SHORT  = 3'b001;
    localparam logic [2:0] EV_LONG   = 3'b010;
    localparam logic [2:0] EV_DOUBLE = 3'b100;

    typedef struct {
        logic [2:0] kind;
        int         at;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clean = 1'b1;
    logic       short_press, long_press, double_press, held;
    logic [7:0] press_count;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'd0;
    exp_t       q[$];

    button_event_fsm #(
        .LONG_TICKS   (20),
        .DOUBLE_TICKS (10),
        .TMR_W        (27),
        .CNT_W        (8)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .CLEAN        (clean),
        .SHORT_PRESS  (short_press),
        .LONG_PRESS   (long_press),
        .DOUBLE_PRESS (double_press),
        .HELD         (held),
        .PRESS_COUNT  (press_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Called at a negedge: the next posedge (cyc+1) is the first to see v, and n posedges see it.
    task automatic hold(input logic v, input int n);
        clean = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input logic [2:0] k, input int at);
        exp_cnt = exp_cnt + 8'd1;
        q.push_back('{k, at, exp_cnt});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() != 0 && cyc > q[0].at) begin
                chk("missed event edge", 32'(cyc), 32'(q[0].at));
                void'(q.pop_front());
            end
            if ({double_press, long_press, short_press} != 3'b000) begin
                if (q.size() == 0) begin
                    chk("unexpected event", 32'({double_press, long_press, short_press}), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("event kind", 32'({double_press, long_press, short_press}), 32'(e.kind));
                    chk("event edge", 32'(cyc), 32'(e.at));
                    chk("event count", 32'(press_count), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        int r, f;
        repeat (3) @(negedge clk);
        chk("reset outputs", 32'({short_press, long_press, double_press, held}), 32'd0);
        chk("reset count", 32'(press_count), 32'd0);
        rst_n = 1'b1;
        // Held through reset release: no rise, and the later fall in IDLE is ignored.
        hold(1'b1, 10);
        hold(1'b0, 15);
        chk("no event after held reset", 32'(press_count), 32'd0);
        // Single short press.
        hold(1'b1, 5);
        f = cyc + 1;
        expect_ev(EV_SHORT, f + 10);
        hold(1'b0, 20);
        chk("count after short", 32'(press_count), 32'd1);
        // Long press with HELD level.
        r = cyc + 1;
        expect_ev(EV_LONG, r + 20);
        hold(1'b1, 30);
        chk("held while long", 32'(held), 32'd1);
        hold(1'b0, 1);
        chk("held after release", 32'(held), 32'd0);
        hold(1'b0, 15);
        chk("count after long", 32'(press_count), 32'd2);
        // Double press.
        hold(1'b1, 4);
        hold(1'b0, 3);
        hold(1'b1, 4);
        expect_ev(EV_DOUBLE, cyc + 1);
        hold(1'b0, 15);
        chk("count after double", 32'(press_count), 32'd3);
        // Fall on the timeout edge takes the short path.
        hold(1'b1, 20);
        expect_ev(EV_SHORT, cyc + 1 + 10);
        hold(1'b0, 15);
        // One edge longer is a long press.
        r = cyc + 1;
        expect_ev(EV_LONG, r + 20);
        hold(1'b1, 21);
        hold(1'b0, 15);
        // Second rise on the window's last edge is a double press.
        hold(1'b1, 3);
        hold(1'b0, 10);
        hold(1'b1, 2);
        expect_ev(EV_DOUBLE, cyc + 1);
        hold(1'b0, 15);
        // One edge later the short fires first and the rise starts a fresh press.
        hold(1'b1, 3);
        expect_ev(EV_SHORT, cyc + 1 + 10);
        hold(1'b0, 11);
        hold(1'b1, 3);
        expect_ev(EV_SHORT, cyc + 1 + 10);
        hold(1'b0, 15);
        chk("count before reset", 32'(press_count), 32'd8);
        // Reset during WAIT_SECOND discards the pending short.
        hold(1'b1, 3);
        hold(1'b0, 4);
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", 32'({short_press, long_press, double_press, held}), 32'd0);
        chk("async reset count", 32'(press_count), 32'd0);
        exp_cnt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 20);
        chk("no short after reset", 32'(press_count), 32'd0);
        // 256 shorts wrap the count back to 0.
        for (int i = 0; i < 256; i++) begin
            hold(1'b1, 2);
            expect_ev(EV_SHORT, cyc + 1 + 10);
            hold(1'b0, 11);
        end
        hold(1'b0, 5);
        chk("count after wrap", 32'(press_count), 32'd0);
        chk("pending events", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
